// File: rtl/tone_decoder.sv
// tone_decoder: measures a square wave's frequency (Hz) and 10-bit duty.
// Optional macro TONE_DECODER_AVG_EN averages over 4 accepted periods.
module tone_decoder #(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned TIMEOUT_CYC = 2_000_000,
    parameter int unsigned MIN_PERIOD  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        pwm_in,
    output logic [31:0] freq,
    output logic [9:0]  duty,
    output logic        valid,
    output logic        locked,
    output logic        dropped
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DIV_F,
        DIV_D,
        OUT
    } state_t;

    state_t state, state_nx;

    logic        s1, s2, s3;
    logic        rise;
    logic [31:0] per_cnt, hi_cnt;
    logic [31:0] p_reg, h_reg;
    logic [31:0] p_sel, h_sel;
    logic [31:0] rem, dvd, fq;
    logic [9:0]  dq;
    logic [4:0]  bit_cnt;
    logic [32:0] rem_sh;
    logic [31:0] rem_nx;
    logic        ge;
    logic        sat;
    logic        short_per;
    logic        accept;
    logic        div_go;
    logic        busy;
    logic        drop;
    logic        timeout;
    logic        clr_cnt;
    logic        last_f, last_d;

    assign rise      = s2 & ~s3;
    assign short_per = per_cnt < 32'(MIN_PERIOD);
    assign accept    = (state == ARMED) && rise && !short_per;
    assign busy      = (state == DIV_F) || (state == DIV_D) || (state == OUT);
    assign drop      = en && rise && (busy || ((state == ARMED) && short_per));
    assign timeout   = en && (state == ARMED) && !rise
                       && (per_cnt >= 32'(TIMEOUT_CYC));
    assign clr_cnt   = !en || ((state == IDLE) && !rise);
    assign last_f    = (state == DIV_F) && (bit_cnt == 5'd31);
    assign last_d    = (state == DIV_D) && (bit_cnt == 5'd9);

    // one restoring-divider step shared by both divisions
    assign rem_sh = {rem, dvd[31]};
    assign ge     = rem_sh >= {1'b0, p_reg};
    assign rem_nx = ge ? (rem_sh[31:0] - p_reg) : rem_sh[31:0];
    assign sat    = h_reg >= p_reg;

`ifdef TONE_DECODER_AVG_EN
    logic [33:0] acc_p, acc_h, sum_p, sum_h;
    logic [1:0]  grp;

    assign sum_p  = acc_p + 34'(per_cnt);
    assign sum_h  = acc_h + 34'(hi_cnt);
    assign div_go = accept && (grp == 2'd3);
    assign p_sel  = 32'(sum_p >> 2);
    assign h_sel  = 32'(sum_h >> 2);

    // accumulate four accepted periods; any drop restarts the group
    always_ff @(posedge clk) begin
        if (rst || !en || drop || state == IDLE) begin
            acc_p <= '0;
            acc_h <= '0;
            grp   <= '0;
        end else if (accept) begin
            if (grp == 2'd3) begin
                acc_p <= '0;
                acc_h <= '0;
                grp   <= '0;
            end else begin
                acc_p <= sum_p;
                acc_h <= sum_h;
                grp   <= grp + 2'd1;
            end
        end
    end
`else
    assign div_go = accept;
    assign p_sel  = per_cnt;
    assign h_sel  = hi_cnt;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // FSM next-state logic; en low overrides everything
    always_comb begin
        state_nx = state;
        if (!en) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (rise) state_nx = ARMED;
                ARMED: begin
                    if (div_go)       state_nx = DIV_F;
                    else if (timeout) state_nx = IDLE;
                end
                DIV_F:   if (last_f) state_nx = DIV_D;
                DIV_D:   if (last_d) state_nx = OUT;
                OUT:     state_nx = ARMED;
                default: state_nx = IDLE;
            endcase
        end
    end

    // synchronizer, edge register and period/high-time counters
    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
            if (clr_cnt) begin
                per_cnt <= '0;
                hi_cnt  <= '0;
            end else if (rise) begin
                per_cnt <= 32'd1;
                hi_cnt  <= 32'd1;
            end else begin
                if (per_cnt < 32'(TIMEOUT_CYC))
                    per_cnt <= per_cnt + 32'd1;
                if (s2 && hi_cnt < 32'(TIMEOUT_CYC))
                    hi_cnt <= hi_cnt + 32'd1;
            end
        end
    end

    // snapshot and serial division: CLK_HZ/P then (H<<10)/P
    always_ff @(posedge clk) begin
        if (rst) begin
            p_reg   <= '0;
            h_reg   <= '0;
            rem     <= '0;
            dvd     <= '0;
            fq      <= '0;
            dq      <= '0;
            bit_cnt <= '0;
        end else if (div_go) begin
            p_reg   <= p_sel;
            h_reg   <= h_sel;
            rem     <= '0;
            dvd     <= 32'(CLK_HZ);
            fq      <= '0;
            bit_cnt <= '0;
        end else if (state == DIV_F) begin
            fq  <= {fq[30:0], ge};
            dvd <= {dvd[30:0], 1'b0};
            if (last_f) begin
                rem     <= h_reg;
                dvd     <= '0;
                dq      <= '0;
                bit_cnt <= '0;
            end else begin
                rem     <= rem_nx;
                bit_cnt <= bit_cnt + 5'd1;
            end
        end else if (state == DIV_D) begin
            dq      <= {dq[8:0], ge};
            rem     <= rem_nx;
            bit_cnt <= bit_cnt + 5'd1;
        end
    end

    // result registers, valid/locked/dropped flags
    always_ff @(posedge clk) begin
        if (rst) begin
            freq    <= '0;
            duty    <= '0;
            valid   <= 1'b0;
            locked  <= 1'b0;
            dropped <= 1'b0;
        end else begin
            valid   <= 1'b0;
            dropped <= drop;
            if (!en) begin
                locked <= 1'b0;
            end else if (timeout) begin
                freq   <= '0;
                duty   <= s2 ? 10'h3FF : 10'h000;
                valid  <= 1'b1;
                locked <= 1'b0;
            end else if (last_d) begin
                freq   <= fq;
                duty   <= sat ? 10'h3FF : {dq[8:0], ge};
                valid  <= 1'b1;
                locked <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tone_decoder.sv
// tb_tone_decoder: directed checks of frequency/duty recovery, drops,
// timeout, enable and reset behaviour (TIMEOUT_CYC shortened to 2000).
module tb_tone_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        pwm_in = 1'b0;
    logic [31:0] freq;
    logic [9:0]  duty;
    logic        valid, locked, dropped;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int vcnt = 0;
    int dcnt = 0;
    int vcyc = 0;
    int rcyc = 0;
    int v0, d0;
    logic [31:0] lf = '0;
    logic [9:0]  ld = '0;

    tone_decoder #(
        .CLK_HZ(100_000_000),
        .TIMEOUT_CYC(2000),
        .MIN_PERIOD(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .pwm_in(pwm_in),
        .freq(freq),
        .duty(duty),
        .valid(valid),
        .locked(locked),
        .dropped(dropped)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // record valid/dropped pulses just after each clock edge
    always @(posedge clk) begin
        #1;
        if (valid) begin
            vcnt = vcnt + 1;
            vcyc = cyc;
            lf   = freq;
            ld   = duty;
        end
        if (dropped) dcnt = dcnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pwm_in = lvl;
            if (i == 0 && lvl) rcyc = cyc;
        end
    endtask

    task automatic run_period(input int per, input int hi);
        drive(1'b1, hi);
        drive(1'b0, per - hi);
    endtask

    initial begin
        drive(1'b0, 4);
        check("rst_freq", freq, 0);
        check("rst_duty", 32'(duty), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_dropped", 32'(dropped), 0);
        rst = 1'b0;
        en  = 1'b1;
        drive(1'b0, 5);

`ifdef TONE_DECODER_AVG_EN
        v0 = vcnt;
        run_period(996, 498);
        run_period(1000, 500);
        run_period(1004, 502);
        run_period(1000, 500);
        drive(1'b1, 60);
        check("avg_vcnt", 32'(vcnt - v0), 1);
        check("avg_freq", lf, 100_000);
        check("avg_duty", 32'(ld), 512);
        check("avg_lat", 32'(vcyc - rcyc), 45);
        check("avg_locked", 32'(locked), 1);
`else
        // 1000-cycle period, 25 % high
        v0 = vcnt;
        d0 = dcnt;
        run_period(1000, 250);
        run_period(1000, 250);
        run_period(1000, 250);
        check("p1k_vcnt", 32'(vcnt - v0), 2);
        check("p1k_freq", lf, 100_000);
        check("p1k_duty", 32'(ld), 256);
        check("p1k_locked", 32'(locked), 1);
        check("p1k_latency", 32'(vcyc - rcyc), 45);
        check("p1k_drops", 32'(dcnt - d0), 0);

        // 75 % high
        run_period(1000, 750);
        run_period(1000, 750);
        check("p1k75_freq", lf, 100_000);
        check("p1k75_duty", 32'(ld), 768);

        // 20-cycle period overruns the 43-cycle divider
        v0 = vcnt;
        d0 = dcnt;
        for (int k = 0; k < 12; k++) run_period(20, 10);
        check("p20_vcnt", 32'(vcnt - v0), 4);
        check("p20_drops", 32'(dcnt - d0), 8);
        check("p20_freq", lf, 5_000_000);
        check("p20_duty", 32'(ld), 512);

        // steady input, then stall high
        run_period(1000, 500);
        run_period(1000, 500);
        run_period(1000, 500);
        v0 = vcnt;
        drive(1'b1, 5000);
        check("to_vcnt", 32'(vcnt - v0), 2);
        check("to_freq", lf, 0);
        check("to_duty", 32'(ld), 1023);
        check("to_locked", 32'(locked), 0);

        // recovery: one edge to arm, one period to measure
        drive(1'b0, 100);
        v0 = vcnt;
        run_period(1000, 500);
        check("rec_locked0", 32'(locked), 0);
        check("rec_vcnt0", 32'(vcnt - v0), 0);
        run_period(1000, 500);
        check("rec_locked1", 32'(locked), 1);
        check("rec_freq", lf, 100_000);
        check("rec_duty", 32'(ld), 512);

        // en dropped while in DIV_D
        v0 = vcnt;
        drive(1'b1, 38);
        en = 1'b0;
        drive(1'b1, 20);
        drive(1'b0, 20);
        check("en_vcnt", 32'(vcnt - v0), 0);
        check("en_freq", freq, 100_000);
        check("en_duty", 32'(duty), 512);
        check("en_locked", 32'(locked), 0);

        // rst during DIV_F
        en = 1'b1;
        drive(1'b0, 50);
        drive(1'b1, 500);
        drive(1'b0, 500);
        v0 = vcnt;
        drive(1'b1, 22);
        rst = 1'b1;
        drive(1'b1, 2);
        rst = 1'b0;
        drive(1'b1, 1);
        check("rst_mid_freq", freq, 0);
        check("rst_mid_duty", 32'(duty), 0);
        check("rst_mid_locked", 32'(locked), 0);
        drive(1'b1, 60);
        check("rst_mid_vcnt", 32'(vcnt - v0), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
